memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/y86_pkg.sv | 105 ++++++++++
 rtl/memory_stage_if.sv | 45 ++++
 rtl/memory_stage_data_mem.sv | 34 +++
 rtl/memory_stage.sv | 98 +++++++++
 tb/tb_memory_stage.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the memory stage: instruction codes, status
// codes, register/memory constants, the M/W pipeline entry type and the
// decode helper that maps an instruction code onto a memory operation.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // "No destination register" marker
    localparam logic [3:0] REG_NONE = 4'hF;

    // Data memory geometry: byte addressed, 8-byte accesses
    localparam int MEM_BYTES = 1024;
    localparam int MEM_AW    = $clog2(MEM_BYTES);
    localparam int WORD_BYTES = 8;

    // Highest legal start address of an 8-byte access
    localparam logic [63:0] MEM_MAX_ADDR = 64'(MEM_BYTES - WORD_BYTES);

    // Kind of data-memory access an instruction performs
    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } memOp_t;

    // Memory control decoded from the instruction code
    typedef struct packed {
        memOp_t op;
        logic   addrFromValA;
        logic   dataFromValP;
    } memCtrl_t;

    // Registered M/W pipeline entry
    typedef struct packed {
        logic        valid;
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } mwEntry_t;

    // Map an instruction code onto its data-memory access.
    // ret/popq address the stack through valA; call stores the return
    // address held in valP; every other icode does not touch memory.
    function automatic memCtrl_t decodeMemCtrl(input logic [3:0] icode);
        memCtrl_t ctrl;
        ctrl.op           = MEM_NONE;
        ctrl.addrFromValA = 1'b0;
        ctrl.dataFromValP = 1'b0;
        case (icode)
            I_RMMOVQ, I_PUSHQ: begin
                ctrl.op = MEM_WRITE;
            end
            I_CALL: begin
                ctrl.op           = MEM_WRITE;
                ctrl.dataFromValP = 1'b1;
            end
            I_MRMOVQ: begin
                ctrl.op = MEM_READ;
            end
            I_RET, I_POPQ: begin
                ctrl.op           = MEM_READ;
                ctrl.addrFromValA = 1'b1;
            end
            default: begin
                ctrl.op = MEM_NONE;
            end
        endcase
        return ctrl;
    endfunction

    // The nop entry the stage emits for bubbles, empty slots and reset
    function automatic mwEntry_t bubbleEntry();
        mwEntry_t e;
        e.valid = 1'b0;
        e.icode = I_NOP;
        e.stat  = STAT_AOK;
        e.valE  = 64'd0;
        e.valM  = 64'd0;
        e.dstE  = REG_NONE;
        e.dstM  = REG_NONE;
        return e;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// E/M input entry, pipeline control and registered M/W output bundle of the
// memory stage. The master side (execute stage / testbench) drives the entry
// and control; the slave side (memory_stage) returns the M/W entry.
interface memory_stage_if;

    // E/M entry
    logic        m_valid;
    logic [3:0]  m_icode;
    logic [2:0]  m_stat_in;
    logic [63:0] m_valE;
    logic [63:0] m_valA;
    logic [63:0] m_valP;
    logic        m_cnd;
    logic [3:0]  m_dstE;
    logic [3:0]  m_dstM;

    // Pipeline control
    logic        stall;
    logic        bubble;

    // M/W entry
    logic        w_valid;
    logic [3:0]  w_icode;
    logic [2:0]  w_stat;
    logic [63:0] w_valE;
    logic [63:0] w_valM;
    logic [3:0]  w_dstE;
    logic [3:0]  w_dstM;
    logic        halted;

    modport master (
        output m_valid, m_icode, m_stat_in, m_valE, m_valA, m_valP,
               m_cnd, m_dstE, m_dstM, stall, bubble,
        input  w_valid, w_icode, w_stat, w_valE, w_valM, w_dstE, w_dstM,
               halted
    );

    modport slave (
        input  m_valid, m_icode, m_stat_in, m_valE, m_valA, m_valP,
               m_cnd, m_dstE, m_dstM, stall, bubble,
        output w_valid, w_icode, w_stat, w_valE, w_valM, w_dstE, w_dstM,
               halted
    );

endinterface

// File: rtl/memory_stage_data_mem.sv
// Byte-array data memory: one combinational little-endian 8-byte read port
// and one synchronous 8-byte write port. Contents are never reset.
module data_mem
    import y86_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [MEM_AW-1:0] i_waddr,
    input  logic [63:0]       i_wdata,
    input  logic [MEM_AW-1:0] i_raddr,
    output logic [63:0]       o_rdata
);

    logic [7:0] r_mem [MEM_BYTES];

    // Assemble the 8 bytes starting at the read address, lowest byte first;
    // byte indices wrap, out-of-range accesses are masked by the caller.
    always_comb begin
        o_rdata = 64'd0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            o_rdata[8*i +: 8] = r_mem[i_raddr + MEM_AW'(i)];
        end
    end

    // Store all 8 bytes of the write word on the accepting edge.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                r_mem[i_waddr + MEM_AW'(i)] <= i_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: decodes the E/M entry into a data-memory access,
// flags out-of-range addresses, and registers the M/W entry with one cycle
// of latency. A sticky halted flag turns every later entry into a bubble.
module memory_stage
    import y86_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    memory_stage_if.slave bus
);

    memCtrl_t    w_ctrl;
    logic [63:0] w_addr;
    logic [63:0] w_wdata;
    logic [63:0] w_rdata;
    logic        w_accept;
    logic        w_addrErr;
    logic        w_memWe;
    mwEntry_t    w_nextOut;

    mwEntry_t    r_out;
    logic        r_halted;

    // Decode the access kind and operand routing from the instruction code.
    assign w_ctrl = decodeMemCtrl(bus.m_icode);

    // An entry is taken only when present, not held, not squashed, not halted.
    assign w_accept = bus.m_valid & ~bus.stall & ~bus.bubble & ~r_halted;

    // Address and write-data routing.
    assign w_addr  = w_ctrl.addrFromValA ? bus.m_valA : bus.m_valE;
    assign w_wdata = w_ctrl.dataFromValP ? bus.m_valP : bus.m_valA;

    // Any access whose 8 bytes do not fit inside the array is an address
    // error; the full 64-bit address is compared so high garbage is caught.
    assign w_addrErr = (w_ctrl.op != MEM_NONE) && (w_addr > MEM_MAX_ADDR);

    // The write lands only for an accepted, in-range store outside reset.
    assign w_memWe = w_accept & ~rst & (w_ctrl.op == MEM_WRITE) & ~w_addrErr;

    data_mem u_dataMem (
        .clk     (clk),
        .i_we    (w_memWe),
        .i_waddr (w_addr[MEM_AW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (w_addr[MEM_AW-1:0]),
        .o_rdata (w_rdata)
    );

    // Build the next M/W entry: the accepted entry, otherwise a nop bubble.
    always_comb begin
        w_nextOut = bubbleEntry();
        if (w_accept) begin
            w_nextOut.valid = 1'b1;
            w_nextOut.icode = bus.m_icode;
            w_nextOut.valE  = bus.m_valE;
            w_nextOut.dstM  = bus.m_dstM;
            if (w_addrErr && (bus.m_stat_in == STAT_AOK)) begin
                w_nextOut.stat = STAT_ADR;
            end else begin
                w_nextOut.stat = bus.m_stat_in;
            end
            if ((w_ctrl.op == MEM_READ) && !w_addrErr) begin
                w_nextOut.valM = w_rdata;
            end else begin
                w_nextOut.valM = 64'd0;
            end
            if ((bus.m_icode == I_RRMOVQ) && !bus.m_cnd) begin
                w_nextOut.dstE = REG_NONE;
            end else begin
                w_nextOut.dstE = bus.m_dstE;
            end
        end
    end

    // Output register and sticky halt flag; stall freezes both.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out    <= bubbleEntry();
            r_halted <= 1'b0;
        end else if (!bus.stall) begin
            r_out <= w_nextOut;
            if (w_accept && (w_nextOut.stat != STAT_AOK)) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign bus.w_valid = r_out.valid;
    assign bus.w_icode = r_out.icode;
    assign bus.w_stat  = r_out.stat;
    assign bus.w_valE  = r_out.valE;
    assign bus.w_valM  = r_out.valM;
    assign bus.w_dstE  = r_out.dstE;
    assign bus.w_dstM  = r_out.dstM;
    assign bus.halted  = r_halted;

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: directed scenarios followed by random traffic,
// every cycle compared against a byte-array reference model of the stage.
module tb_memory_stage;

    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;
    localparam logic [3:0] RNONE = 4'hF;
    localparam int NBYTES = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;

    memory_stage_if bus ();

    memory_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  mMem   [NBYTES];
    bit          mKnown [NBYTES];
    logic        eValid;
    logic [3:0]  eIcode;
    logic [2:0]  eStat;
    logic [63:0] eValE;
    logic [63:0] eValM;
    bit          eValMKnown;
    logic [3:0]  eDstE;
    logic [3:0]  eDstM;
    logic        eHalted;

    task automatic setBubble();
        eValid = 1'b0; eIcode = 4'h1; eStat = AOK; eValE = 64'd0;
        eValM = 64'd0; eValMKnown = 1'b1; eDstE = RNONE; eDstM = RNONE;
    endtask

    task automatic checkField(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkField({tag, ".w_valid"}, 64'(bus.w_valid), 64'(eValid));
        checkField({tag, ".w_icode"}, 64'(bus.w_icode), 64'(eIcode));
        checkField({tag, ".w_stat"},  64'(bus.w_stat),  64'(eStat));
        checkField({tag, ".w_valE"},  bus.w_valE, eValE);
        if (eValMKnown) checkField({tag, ".w_valM"}, bus.w_valM, eValM);
        checkField({tag, ".w_dstE"},  64'(bus.w_dstE),  64'(eDstE));
        checkField({tag, ".w_dstM"},  64'(bus.w_dstM),  64'(eDstM));
        checkField({tag, ".halted"},  64'(bus.halted),  64'(eHalted));
    endtask

    // Drive one cycle, advance the model by the stage's rules, then check.
    task automatic applyStimulus(input string tag, input bit r, input bit v,
                                 input logic [3:0] ic, input logic [2:0] st,
                                 input logic [63:0] vE, input logic [63:0] vA,
                                 input logic [63:0] vP, input bit c,
                                 input logic [3:0] dE, input logic [3:0] dM,
                                 input bit stl, input bit bub);
        bit isRd, isWr, err;
        logic [63:0] addr, data;
        int a;
        rst = r; bus.m_valid = v; bus.m_icode = ic; bus.m_stat_in = st;
        bus.m_valE = vE; bus.m_valA = vA; bus.m_valP = vP; bus.m_cnd = c;
        bus.m_dstE = dE; bus.m_dstM = dM; bus.stall = stl; bus.bubble = bub;
        if (r) begin
            setBubble();
            eHalted = 1'b0;
        end else if (stl) begin
            // outputs and memory hold
        end else if (!v || bub || eHalted) begin
            setBubble();
        end else begin
            isRd = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
            isWr = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
            addr = ((ic == 4'h9) || (ic == 4'hB)) ? vA : vE;
            err  = (isRd || isWr) && (addr > 64'd1016);
            eStat = (err && (st == AOK)) ? ADR : st;
            eValM = 64'd0;
            eValMKnown = 1'b1;
            a = int'(addr[9:0]);
            if (isRd && !err) begin
                for (int i = 0; i < 8; i++) begin
                    eValM[8*i +: 8] = mMem[a + i];
                    if (!mKnown[a + i]) eValMKnown = 1'b0;
                end
            end
            if (isWr && !err) begin
                data = (ic == 4'h8) ? vP : vA;
                for (int i = 0; i < 8; i++) begin
                    mMem[a + i]   = data[8*i +: 8];
                    mKnown[a + i] = 1'b1;
                end
            end
            eValid = 1'b1; eIcode = ic; eValE = vE; eDstM = dM;
            eDstE = ((ic == 4'h2) && !c) ? RNONE : dE;
            if (eStat != AOK) eHalted = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Shorthand for an AOK entry with no control asserted.
    task automatic op(input string tag, input logic [3:0] ic, input logic [63:0] vE,
                      input logic [63:0] vA, input logic [63:0] vP);
        applyStimulus(tag, 1'b0, 1'b1, ic, AOK, vE, vA, vP, 1'b1, 4'h2, 4'h5, 1'b0, 1'b0);
    endtask

    // Directed scenarios, then random traffic, then the summary.
    initial begin
        logic [63:0] addr, vA, d;
        logic [3:0]  ic;
        eHalted = 1'b0;
        setBubble();

        applyStimulus("reset0", 1'b1, 1'b0, 4'h0, AOK, 0, 0, 0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        applyStimulus("reset1", 1'b1, 1'b0, 4'h0, AOK, 0, 0, 0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

        // Fill the regions read later with known data.
        for (int k = 0; k < 32; k++) op("init", 4'h4, 64'(k * 8), {$urandom, $urandom}, 0);
        op("init_hi0", 4'h4, 64'd1000, {$urandom, $urandom}, 0);
        op("init_hi1", 4'h4, 64'd1008, {$urandom, $urandom}, 0);
        op("init_hi2", 4'h4, 64'd1016, 64'h0102030405060708, 0);

        // Entry arriving with reset is dropped, its write too.
        applyStimulus("rst_entry", 1'b1, 1'b1, 4'h4, AOK, 64'h30, 64'hDEADBEEFDEADBEEF, 0, 1'b1, 4'h1, 4'h2, 1'b0, 1'b0);
        op("rst_entry_rd", 4'h5, 64'h30, 0, 0);

        // Write then read back.
        op("wr_10", 4'h4, 64'h10, 64'h1122334455667788, 0);
        op("rd_10", 4'h5, 64'h10, 0, 0);
        checkField("rd_10.value", bus.w_valM, 64'h1122334455667788);

        // Conditional move.
        applyStimulus("cmov_nc", 1'b0, 1'b1, 4'h2, AOK, 64'h7, 64'h7, 0, 1'b0, 4'h3, 4'hF, 1'b0, 1'b0);
        checkField("cmov_nc.dstE", 64'(bus.w_dstE), 64'hF);
        applyStimulus("cmov_c", 1'b0, 1'b1, 4'h2, AOK, 64'h7, 64'h7, 0, 1'b1, 4'h3, 4'hF, 1'b0, 1'b0);
        checkField("cmov_c.dstE", 64'(bus.w_dstE), 64'h3);

        // call / ret.
        op("call", 4'h8, 64'h100, 64'h108, 64'h44);
        op("ret", 4'h9, 64'h108, 64'h100, 0);
        checkField("ret.value", bus.w_valM, 64'h44);

        // Stall, stall+bubble, bubble.
        op("pre_stall", 4'h6, 64'h55, 0, 0);
        for (int k = 0; k < 3; k++)
            applyStimulus("stall", 1'b0, 1'b1, 4'hA, AOK, 64'h40, 64'hAAAA, 0, 1'b1, 4'h4, 4'hF, 1'b1, 1'b0);
        applyStimulus("stall_bub", 1'b0, 1'b1, 4'hA, AOK, 64'h40, 64'hAAAA, 0, 1'b1, 4'h4, 4'hF, 1'b1, 1'b1);
        applyStimulus("bubble", 1'b0, 1'b1, 4'hA, AOK, 64'h40, 64'hAAAA, 0, 1'b1, 4'h4, 4'hF, 1'b0, 1'b1);
        op("post_stall_rd", 4'h5, 64'h40, 0, 0);
        op("push", 4'hA, 64'h40, 64'hAAAA, 0);
        op("pop", 4'hB, 64'h48, 64'h40, 0);
        checkField("pop.value", bus.w_valM, 64'hAAAA);

        // Partial overlap.
        op("wr_60", 4'h4, 64'h60, 64'h8877665544332211, 0);
        op("rd_64", 4'h5, 64'h64, 0, 0);

        // Address boundary and halt.
        op("rd_1016", 4'h5, 64'd1016, 0, 0);
        checkField("rd_1016.value", bus.w_valM, 64'h0102030405060708);
        op("rd_1017", 4'h5, 64'd1017, 0, 0);
        checkField("rd_1017.stat", 64'(bus.w_stat), 64'(ADR));
        op("halted_wr", 4'h4, 64'h20, 64'hFF, 0);
        applyStimulus("rst_halt", 1'b1, 1'b0, 4'h0, AOK, 0, 0, 0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        op("rd_20", 4'h5, 64'h20, 0, 0);

        // Non-AOK upstream status and invalid icode.
        applyStimulus("ins", 1'b0, 1'b1, 4'hE, INS, 64'h20, 64'h20, 0, 1'b1, 4'h1, 4'h2, 1'b0, 1'b0);
        applyStimulus("rst_ins", 1'b1, 1'b0, 4'h0, AOK, 0, 0, 0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        applyStimulus("hlt", 1'b0, 1'b1, 4'h0, HLT, 64'h9, 0, 0, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0);
        applyStimulus("rst_hlt", 1'b1, 1'b0, 4'h0, AOK, 0, 0, 0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(9) == 0) addr = 64'd1000 + 64'($urandom_range(30));
            else addr = 64'($urandom_range(248));
            if ($urandom_range(49) == 0) addr = {$urandom, $urandom};
            ic = 4'($urandom_range(15));
            d  = {$urandom, $urandom};
            vA = ((ic == 4'h9) || (ic == 4'hB)) ? addr : d;
            applyStimulus(eHalted ? "rnd_rst" : "rnd", eHalted && ($urandom_range(3) == 0),
                          $urandom_range(9) != 0, ic, ($urandom_range(49) == 0) ? INS : AOK,
                          addr, vA, {$urandom, $urandom}, 1'($urandom_range(1)),
                          4'($urandom_range(15)), 4'($urandom_range(15)),
                          $urandom_range(9) == 0, $urandom_range(9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
